// File: rtl/truco_placar_multi.sv
// truco_placar_multi: N-team truco scoreboard with debounced buttons.
// Optional macro TRUCO_UNDO_EN adds a one-level undo button (undo_n).
module truco_placar_multi #(
    parameter int NUM_TEAMS    = 2,
    parameter int POINTS_MAX   = 12,
    parameter int TENTOS_MAX   = 3,
    parameter int DEBOUNCE_CYC = 4,
    localparam int PW = $clog2(POINTS_MAX + 1),
    localparam int TW = $clog2(TENTOS_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_TEAMS-1:0]    btn_n,
    input  logic [3:0]              pts_val,
    input  logic                    new_game,
`ifdef TRUCO_UNDO_EN
    input  logic                    undo_n,
`endif
    output logic [NUM_TEAMS*PW-1:0] pontos,
    output logic [NUM_TEAMS*TW-1:0] tentos,
    output logic [1:0]              vencedor,
    output logic                    fim_jogo,
    output logic                    busy
);

    localparam int SW = (NUM_TEAMS > 1) ? $clog2(NUM_TEAMS) : 1;
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic [3:0] {
        S_INICIO,
        S_ESPERA,
        S_DEBOUNCE,
        S_FILTRO,
        S_ADD,
        S_CHECK,
        S_TENTO,
        S_CHECK_T,
        S_FINAL,
        S_UNDO
    } state_t;

    state_t state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    val_q, val_d;
    logic [NUM_TEAMS-1:0][PW-1:0] pts_q, pts_d;
    logic [NUM_TEAMS-1:0][TW-1:0] ten_q, ten_d;
    logic [1:0]    venc_q, venc_d;
    logic          fim_q, fim_d;
    logic          busy_q, busy_d;

`ifdef TRUCO_UNDO_EN
    logic          und_q, und_d;
    logic          snap_ok_q, snap_ok_d;
    logic [NUM_TEAMS-1:0][PW-1:0] snap_pts_q, snap_pts_d;
    logic [NUM_TEAMS-1:0][TW-1:0] snap_ten_q, snap_ten_d;
`endif

    logic          any_low;
    logic [SW-1:0] low_idx;
    logic          btn_w;
    logic [PW+3:0] sum;

    // Wide add so the saturating compare never sees a wrapped value
    assign sum = (PW+4)'(pts_q[sel_q]) + (PW+4)'(val_q);

    // Lowest-index pressed button wins on simultaneous presses
    always_comb begin
        any_low = 1'b0;
        low_idx = '0;
        for (int i = NUM_TEAMS - 1; i >= 0; i--) begin
            if (!btn_n[i]) begin
                any_low = 1'b1;
                low_idx = SW'(i);
            end
        end
    end

    // Button being debounced/released: the selected team or undo
    always_comb begin
        btn_w = btn_n[sel_q];
`ifdef TRUCO_UNDO_EN
        if (und_q) begin
            btn_w = undo_n;
        end
`endif
    end

    // Next-state and next-output decode
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        pts_d   = pts_q;
        ten_d   = ten_q;
        venc_d  = venc_q;
`ifdef TRUCO_UNDO_EN
        und_d      = und_q;
        snap_ok_d  = snap_ok_q;
        snap_pts_d = snap_pts_q;
        snap_ten_d = snap_ten_q;
`endif
        unique case (state_q)
            S_INICIO: begin
                pts_d   = '0;
                ten_d   = '0;
                venc_d  = '0;
`ifdef TRUCO_UNDO_EN
                snap_ok_d = 1'b0;
`endif
                state_d = S_ESPERA;
            end
            S_ESPERA: begin
                if (any_low) begin
                    sel_d   = low_idx;
                    cnt_d   = CW'(1);
`ifdef TRUCO_UNDO_EN
                    und_d   = 1'b0;
`endif
                    state_d = S_DEBOUNCE;
                end
`ifdef TRUCO_UNDO_EN
                else if (!undo_n) begin
                    und_d   = 1'b1;
                    cnt_d   = CW'(1);
                    state_d = S_DEBOUNCE;
                end
`endif
            end
            S_DEBOUNCE: begin
                if (cnt_q == CW'(DEBOUNCE_CYC)) begin
                    val_d   = (pts_val == 4'd0) ? 4'd1 : pts_val;
                    state_d = S_FILTRO;
                end else if (btn_w) begin
                    state_d = S_ESPERA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FILTRO: begin
                if (btn_w) begin
`ifdef TRUCO_UNDO_EN
                    state_d = und_q ? S_UNDO : S_ADD;
`else
                    state_d = S_ADD;
`endif
                end
            end
            S_ADD: begin
                if (sum > (PW+4)'(POINTS_MAX)) begin
                    pts_d[sel_q] = PW'(POINTS_MAX);
                end else begin
                    pts_d[sel_q] = sum[PW-1:0];
                end
`ifdef TRUCO_UNDO_EN
                snap_pts_d = pts_q;
                snap_ten_d = ten_q;
                snap_ok_d  = 1'b1;
`endif
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (pts_q[sel_q] == PW'(POINTS_MAX)) begin
                    state_d = S_TENTO;
                end else begin
                    state_d = S_ESPERA;
                end
            end
            S_TENTO: begin
                pts_d        = '0;
                ten_d[sel_q] = ten_q[sel_q] + TW'(1);
                state_d      = S_CHECK_T;
            end
            S_CHECK_T: begin
                if (ten_q[sel_q] == TW'(TENTOS_MAX)) begin
                    venc_d  = 2'(sel_q);
                    state_d = S_FINAL;
                end else begin
                    state_d = S_ESPERA;
                end
            end
            S_FINAL: begin
                if (new_game) begin
                    state_d = S_INICIO;
                end
            end
            S_UNDO: begin
`ifdef TRUCO_UNDO_EN
                if (snap_ok_q) begin
                    pts_d = snap_pts_q;
                    ten_d = snap_ten_q;
                end
                snap_ok_d = 1'b0;
`endif
                state_d = S_ESPERA;
            end
            default: begin
                state_d = S_INICIO;
            end
        endcase
        fim_d  = (state_d == S_FINAL);
        busy_d = !((state_d == S_ESPERA) || (state_d == S_FINAL));
    end

    // State and registered outputs; reset wins in every state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INICIO;
            sel_q   <= '0;
            cnt_q   <= '0;
            val_q   <= '0;
            pts_q   <= '0;
            ten_q   <= '0;
            venc_q  <= '0;
            fim_q   <= 1'b0;
            busy_q  <= 1'b1;
`ifdef TRUCO_UNDO_EN
            und_q      <= 1'b0;
            snap_ok_q  <= 1'b0;
            snap_pts_q <= '0;
            snap_ten_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            pts_q   <= pts_d;
            ten_q   <= ten_d;
            venc_q  <= venc_d;
            fim_q   <= fim_d;
            busy_q  <= busy_d;
`ifdef TRUCO_UNDO_EN
            und_q      <= und_d;
            snap_ok_q  <= snap_ok_d;
            snap_pts_q <= snap_pts_d;
            snap_ten_q <= snap_ten_d;
`endif
        end
    end

    assign pontos   = pts_q;
    assign tentos   = ten_q;
    assign vencedor = venc_q;
    assign fim_jogo = fim_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_truco_placar_multi.sv
// tb_truco_placar_multi: scoreboard bench for the truco scoreboard.
// Exercises presses, debounce, saturation, tentos, final and reset.
module tb_truco_placar_multi;

    localparam int NT = 2;
    localparam int PM = 12;
    localparam int TM = 3;
    localparam int DC = 4;
    localparam int PW = $clog2(PM + 1);
    localparam int TW = $clog2(TM + 1);
    localparam int UNDO_ID = NT;

    logic              clk = 1'b0;
    logic              reset;
    logic [NT-1:0]     btn_n;
    logic [3:0]        pts_val;
    logic              new_game;
`ifdef TRUCO_UNDO_EN
    logic              undo_n;
`endif
    logic [NT*PW-1:0]  pontos;
    logic [NT*TW-1:0]  tentos;
    logic [1:0]        vencedor;
    logic              fim_jogo;
    logic              busy;

    truco_placar_multi #(
        .NUM_TEAMS(NT),
        .POINTS_MAX(PM),
        .TENTOS_MAX(TM),
        .DEBOUNCE_CYC(DC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_n(btn_n),
        .pts_val(pts_val),
        .new_game(new_game),
`ifdef TRUCO_UNDO_EN
        .undo_n(undo_n),
`endif
        .pontos(pontos),
        .tentos(tentos),
        .vencedor(vencedor),
        .fim_jogo(fim_jogo),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NT*PW-1:0] p;
        logic [NT*TW-1:0] t;
        logic             f;
        logic [1:0]       v;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    int mp[NT];
    int mt[NT];
    int sp[NT];
    int st[NT];
    bit sv;
    bit mfim;
    int mven;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NT; i++) begin
            mp[i] = 0;
            mt[i] = 0;
        end
        sv   = 1'b0;
        mfim = 1'b0;
        mven = 0;
    endtask

    task automatic model_press(input int who, input int val);
        int v;
        if (mfim) return;
        if (who == UNDO_ID) begin
            if (sv) begin
                mp = sp;
                mt = st;
            end
            sv = 1'b0;
            return;
        end
        v  = (val == 0) ? 1 : val;
        sp = mp;
        st = mt;
        sv = 1'b1;
        mp[who] = (mp[who] + v > PM) ? PM : mp[who] + v;
        if (mp[who] == PM) begin
            for (int i = 0; i < NT; i++) mp[i] = 0;
            mt[who]++;
            if (mt[who] == TM) begin
                mfim = 1'b1;
                mven = who;
            end
        end
    endtask

    task automatic push_model();
        exp_t e;
        e = '0;
        for (int i = 0; i < NT; i++) begin
            e.p[i*PW +: PW] = PW'(mp[i]);
            e.t[i*TW +: TW] = TW'(mt[i]);
        end
        e.f = mfim;
        e.v = 2'(mven);
        q.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 40);
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        e = q.pop_front();
        chk({tag, "_pontos"}, 32'(pontos), 32'(e.p));
        chk({tag, "_tentos"}, 32'(tentos), 32'(e.t));
        chk({tag, "_fim"}, 32'(fim_jogo), 32'(e.f));
        if (e.f) chk({tag, "_venc"}, 32'(vencedor), 32'(e.v));
    endtask

    task automatic drive_btn(input int who, input logic lvl);
        if (who == UNDO_ID) begin
`ifdef TRUCO_UNDO_EN
            undo_n = lvl;
`endif
        end else begin
            btn_n[who] = lvl;
        end
    endtask

    task automatic press(input string tag, input int who, input int hold,
                         input int val);
        pts_val = 4'(val);
        @(negedge clk);
        drive_btn(who, 1'b0);
        repeat (hold) @(negedge clk);
        drive_btn(who, 1'b1);
        if (hold >= DC) model_press(who, val);
        push_model();
        wait_idle();
        compare(tag);
    endtask

    initial begin
        reset    = 1'b1;
        btn_n    = '1;
        pts_val  = 4'd0;
        new_game = 1'b0;
`ifdef TRUCO_UNDO_EN
        undo_n   = 1'b1;
`endif
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_pontos", 32'(pontos), 32'd0);
        chk("rst_tentos", 32'(tentos), 32'd0);
        chk("rst_fim", 32'(fim_jogo), 32'd0);
        chk("rst_venc", 32'(vencedor), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        push_model();
        wait_idle();
        compare("init");

        press("t0_plus3", 0, 4, 3);

        pts_val = 4'd2;
        @(negedge clk);
        btn_n[1] = 1'b0;
        repeat (6) @(negedge clk);
        btn_n[1] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("latency_p1", 32'(pontos[PW +: PW]), 32'd2);
        model_press(1, 2);
        push_model();
        wait_idle();
        compare("t1_plus2");

        press("bounce3", 0, 3, 5);

        pts_val = 4'd1;
        @(negedge clk);
        btn_n = '0;
        repeat (DC) @(negedge clk);
        btn_n = '1;
        model_press(0, 1);
        push_model();
        wait_idle();
        compare("both");

        press("t1_plus7", 1, 4, 7);
        press("t1_sat", 1, 5, 6);

        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        push_model();
        wait_idle();
        compare("ng_ignored");

        press("val0", 0, 4, 0);
        press("t0_tento1", 0, 4, 12);
        press("t0_tento2", 0, 4, 12);
        press("t0_11", 0, 4, 11);
        press("t0_win", 0, 4, 1);
        press("final_frozen", 1, 5, 5);
        chk("final_busy", 32'(busy), 32'd0);

        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
        push_model();
        wait_idle();
        compare("new_game");

        press("t1_plus5", 1, 4, 5);

        pts_val = 4'd3;
        @(negedge clk);
        btn_n[0] = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_clear();
        chk("midrst_pontos", 32'(pontos), 32'd0);
        chk("midrst_tentos", 32'(tentos), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        btn_n[0] = 1'b1;
        push_model();
        wait_idle();
        repeat (4) @(negedge clk);
        compare("after_rst");

`ifdef TRUCO_UNDO_EN
        press("u_plus5", 0, 4, 5);
        press("u_plus3", 0, 4, 3);
        press("undo1", UNDO_ID, 4, 0);
        press("undo2", UNDO_ID, 4, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
